// File: rtl/seq_req_queue_pkg.sv
// Shared types and helpers for the four-input request queue.
package seq_req_queue_pkg;

  localparam int NUM_REQS = 4;

  typedef logic [1:0] src_idx_t;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic src_idx_t onehot_to_idx(input logic [NUM_REQS-1:0] vec);
    src_idx_t idx;
    idx = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (vec[i]) idx = src_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seq_req_queue_fifo.sv
// One circular-buffer queue: enqueue/dequeue, occupancy count, full/empty, head.
// Pointers wrap naturally because p_depth is a power of two.
module seq_req_queue_fifo #(
  parameter int p_nbits = 8,
  parameter int p_depth = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  input  logic [p_nbits-1:0] enq_msg,
  input  logic               deq_val,
  output logic               full,
  output logic               empty,
  output logic [p_nbits-1:0] head
);

  localparam int PW = $clog2(p_depth);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0]      ptr_t;
  typedef logic [CW-1:0]      cnt_t;
  typedef logic [p_nbits-1:0] msg_t;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t cnt_q, cnt_d;
  msg_t mem_q [p_depth];
  msg_t mem_d [p_depth];

  logic do_enq;
  logic do_deq;

  assign full  = (cnt_q == cnt_t'(p_depth));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next-state for pointers, count and storage; a full queue only takes a
  // write when its head leaves in the same cycle.
  always_comb begin
    do_deq   = deq_val && !empty;
    do_enq   = enq_val && (!full || do_deq);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (do_enq) begin
      mem_d[wr_ptr_q] = enq_msg;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (do_deq) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    case ({do_enq, do_deq})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers; reset discards any queued data at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Message storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/seq_req_queue_4in.sv
// Four-input request queue feeding a 4-input rotating arbiter.
// Optional macro SEQ_REQ_QUEUE_FULL_RDY_EN: a full queue also reports ready
// in the cycle its head is granted, so it can refill without a bubble.
//
// Handshakes: on the input side a message transfers at the clock edge where
// in_val[i] && in_rdy[i]; in_val may be held while in_rdy is low and nothing
// is dropped. On the output side out_val has no back-pressure: a grant that
// hits a non-empty queue dequeues its head at the next edge.
module seq_req_queue_4in
  import seq_req_queue_pkg::*;
#(
  parameter int p_nbits = 8,
  parameter int p_depth = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQS-1:0]         in_val,
  output logic [NUM_REQS-1:0]         in_rdy,
  input  logic [NUM_REQS*p_nbits-1:0] in_msg,
  output logic [NUM_REQS-1:0]         reqs,
  input  logic [NUM_REQS-1:0]         grants,
  output logic                        out_val,
  output logic [p_nbits-1:0]          out_msg,
  output src_idx_t                    out_src
);

  logic [NUM_REQS-1:0] full;
  logic [NUM_REQS-1:0] empty;
  logic [NUM_REQS-1:0] enq_vec;
  logic [NUM_REQS-1:0] deq_vec;
  logic [p_nbits-1:0]  head [NUM_REQS];
  src_idx_t            gnt_idx;
  logic                gnt_hit;

  // Requests come straight from registered occupancy.
  assign reqs    = ~empty;
  assign enq_vec = in_val & in_rdy;

  // Grant qualification and output mux; multi-hot grants resolve to the
  // lowest set index, and a grant to an empty queue is ignored.
  always_comb begin
    gnt_idx = onehot_to_idx(grants);
    gnt_hit = (|grants) && reqs[gnt_idx];
    deq_vec = '0;
    out_val = 1'b0;
    out_msg = '0;
    out_src = '0;
    if (gnt_hit) begin
      deq_vec[gnt_idx] = 1'b1;
      out_val          = 1'b1;
      out_msg          = head[gnt_idx];
      out_src          = gnt_idx;
    end
  end

  // Input ready; the optional form uses the qualified dequeue so that an
  // illegal multi-hot grant can never open a full queue that is not drained.
  always_comb begin
`ifdef SEQ_REQ_QUEUE_FULL_RDY_EN
    in_rdy = ~full | deq_vec;
`else
    in_rdy = ~full;
`endif
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_q
    seq_req_queue_fifo #(
      .p_nbits (p_nbits),
      .p_depth (p_depth)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .enq_val (enq_vec[i]),
      .enq_msg (in_msg[i*p_nbits +: p_nbits]),
      .deq_val (deq_vec[i]),
      .full    (full[i]),
      .empty   (empty[i]),
      .head    (head[i])
    );
  end

endmodule

// File: tb/tb_seq_req_queue_4in.sv
// Bench for seq_req_queue_4in: directed scenarios plus a rotating-arbiter
// co-simulation; outputs are checked against an expected-output queue.
module tb_seq_req_queue_4in;

`ifdef SEQ_REQ_QUEUE_FULL_RDY_EN
  localparam bit FULL_RDY = 1'b1;
`else
  localparam bit FULL_RDY = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  in_val;
  logic [3:0]  in_rdy;
  logic [31:0] in_msg;
  logic [3:0]  reqs;
  logic [3:0]  grants;
  logic [3:0]  drv_grants;
  logic [3:0]  arb_gnt;
  logic        arb_mode;
  logic [1:0]  arb_ptr;
  logic        out_val;
  logic [7:0]  out_msg;
  logic [1:0]  out_src;

  logic [9:0]  exp_q[$];   // {src, msg} in expected delivery order
  int          n_checks;
  int          n_fail;
  int          illegal_cnt;

  seq_req_queue_4in #(.p_nbits(8), .p_depth(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .reqs    (reqs),
    .grants  (grants),
    .out_val (out_val),
    .out_msg (out_msg),
    .out_src (out_src)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  assign grants = arb_mode ? arb_gnt : drv_grants;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[3]) r = 2'd3;
    if (v[2]) r = 2'd2;
    if (v[1]) r = 2'd1;
    if (v[0]) r = 2'd0;
    return r;
  endfunction

  // reference rotating arbiter: first request at or after the pointer
  always_comb begin
    int j;
    arb_gnt = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      j = (int'(arb_ptr) + k) % 4;
      if (arb_gnt == 4'b0000 && reqs[j]) arb_gnt[j] = 1'b1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) arb_ptr <= 2'd0;
    else if (arb_mode && arb_gnt != 4'b0000) arb_ptr <= low_idx(arb_gnt) + 2'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor; also records multi-hot grant cycles
  always @(negedge clk) begin
    logic [9:0] e;
    if (!reset && $countones(grants) > 1) illegal_cnt++;
    if (!reset && out_val) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {22'd0, out_src, out_msg}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_src", 32'(out_src), 32'(e[9:8]));
        check("sb_msg", 32'(out_msg), 32'(e[7:0]));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_msg(input int i, input logic [7:0] v);
    in_msg[i*8 +: 8] = v;
  endtask

  task automatic push_one(input int i, input logic [7:0] v);
    in_val    = 4'b0000;
    in_val[i] = 1'b1;
    set_msg(i, v);
    exp_q.push_back({2'(i), v});
    tick();
    in_val = 4'b0000;
  endtask

  task automatic grant_n(input logic [3:0] g, input int n);
    drv_grants = g;
    for (int k = 0; k < n; k++) tick();
    drv_grants = 4'b0000;
  endtask

  initial begin
    logic [7:0] v;
    n_checks    = 0;
    n_fail      = 0;
    illegal_cnt = 0;
    reset       = 1'b1;
    in_val      = 4'b0000;
    in_msg      = 32'd0;
    drv_grants  = 4'b0000;
    arb_mode    = 1'b0;

    // reset state
    tick(); tick();
    samp();
    check("rst_reqs", 32'(reqs), 32'h0);
    check("rst_in_rdy", 32'(in_rdy), 32'hF);
    check("rst_out_val", 32'(out_val), 32'h0);
    check("rst_out_msg", 32'(out_msg), 32'h0);
    check("rst_out_src", 32'(out_src), 32'h0);
    tick();
    reset = 1'b0;

    // enqueue latency: one cycle from enqueue to request
    in_val = 4'b0100;
    set_msg(2, 8'hA5);
    exp_q.push_back({2'd2, 8'hA5});
    samp();
    check("lat_reqs_pre", 32'(reqs), 32'h0);
    tick();
    in_val     = 4'b0000;
    drv_grants = 4'b0100;
    samp();
    check("lat_reqs_post", 32'(reqs), 32'h4);
    check("lat_out_val", 32'(out_val), 32'h1);
    check("lat_out_msg", 32'(out_msg), 32'hA5);
    check("lat_out_src", 32'(out_src), 32'h2);
    tick();
    drv_grants = 4'b0000;
    samp();
    check("lat_reqs_drained", 32'(reqs), 32'h0);

    // FIFO order, full hold-off, pointer wrap on q0
    tick();
    push_one(0, 8'h11);
    push_one(0, 8'h22);
    samp();
    check("q0_full_rdy", 32'(in_rdy[0]), 32'h0);
    check("q0_reqs", 32'(reqs[0]), 32'h1);
    in_val = 4'b0001;          // held off while full, must not be taken
    set_msg(0, 8'h99);
    tick();
    in_val = 4'b0000;
    grant_n(4'b0001, 1);       // 11
    push_one(0, 8'h33);
    grant_n(4'b0001, 2);       // 22, 33
    samp();
    check("q0_drained", 32'(reqs[0]), 32'h0);

    // full handshake on q1
    tick();
    push_one(1, 8'h44);
    push_one(1, 8'h55);
    in_val     = 4'b0010;
    set_msg(1, 8'h66);
    drv_grants = 4'b0010;
    if (FULL_RDY) exp_q.push_back({2'd1, 8'h66});
    samp();
    check("q1_full_gnt_rdy", 32'(in_rdy[1]), FULL_RDY ? 32'h1 : 32'h0);
    tick();
    in_val     = 4'b0000;
    drv_grants = 4'b0000;
    samp();
    check("q1_after_rdy", 32'(in_rdy[1]), FULL_RDY ? 32'h0 : 32'h1);
    tick();
    grant_n(4'b0010, FULL_RDY ? 2 : 1);
    samp();
    check("q1_drained", 32'(reqs[1]), 32'h0);

    // grant to empty queue is ignored
    tick();
    drv_grants = 4'b1000;
    samp();
    check("gempty_out_val", 32'(out_val), 32'h0);
    check("gempty_out_msg", 32'(out_msg), 32'h0);
    check("gempty_out_src", 32'(out_src), 32'h0);
    tick();
    drv_grants = 4'b0000;

    // multi-hot grant: only the lowest index is served
    in_val = 4'b0011;
    set_msg(0, 8'h77);
    set_msg(1, 8'h88);
    exp_q.push_back({2'd0, 8'h77});
    exp_q.push_back({2'd1, 8'h88});
    tick();
    in_val     = 4'b0000;
    drv_grants = 4'b0011;
    $display("note: driving illegal multi-hot grants 0011");
    samp();
    check("multi_out_src", 32'(out_src), 32'h0);
    check("multi_out_msg", 32'(out_msg), 32'h77);
    tick();
    drv_grants = 4'b0000;
    samp();
    check("multi_reqs", 32'(reqs), 32'h2);
    check("nogrant_out_val", 32'(out_val), 32'h0);
    check("nogrant_out_msg", 32'(out_msg), 32'h0);
    tick();
    grant_n(4'b0010, 1);
    samp();
    check("illegal_flagged", 32'(illegal_cnt), 32'h1);

    // reset mid-stream with two items queued in q2
    tick();
    push_one(2, 8'hC1);
    in_val = 4'b0100;
    set_msg(2, 8'hC2);
    tick();
    in_val     = 4'b0000;
    drv_grants = 4'b0100;
    samp();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_reqs", 32'(reqs), 32'h0);
    check("mid_rst_in_rdy", 32'(in_rdy), 32'hF);
    check("mid_rst_out_val", 32'(out_val), 32'h0);
    drv_grants = 4'b0000;
    tick();
    reset = 1'b0;
    samp();
    check("post_rst_reqs", 32'(reqs), 32'h0);

    // arbiter co-simulation: two messages per queue, grants fed back
    tick();
    arb_mode = 1'b1;
    for (int r = 0; r < 2; r++) begin
      in_val = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        v = 8'($urandom_range(0, 255));
        set_msg(i, v);
        exp_q.push_back({2'(i), v});
      end
      samp();
      check("cosim_load_rdy", 32'(in_rdy), 32'hF);
      tick();
    end
    in_val = 4'b0000;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) samp();
    samp();
    check("cosim_drained", 32'(exp_q.size()), 32'h0);
    check("cosim_reqs", 32'(reqs), 32'h0);
    arb_mode = 1'b0;

    tick();
    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
